// File: rtl/restoring_divider_n.sv
// Multi-cycle unsigned restoring divider with valid/ready handshakes on both sides.
// Optional feature macro: DIVIDER_DBZ_EN (divide-by-zero flag and single-cycle shortcut).

module subtractor_n #(
  parameter int nb_bit = 8
) (
  input  logic [nb_bit-1:0] a_i,
  input  logic [nb_bit-1:0] b_i,
  output logic [nb_bit-1:0] diff_o,
  output logic              borrow_o
);

  // Zero-extended subtraction: the extra top bit is the borrow out (set when a_i < b_i).
  always_comb begin
    {borrow_o, diff_o} = {1'b0, a_i} - {1'b0, b_i};
  end

endmodule

module restoring_divider_n #(
  parameter int nb_bit = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [nb_bit-1:0] dividend_i,
  input  logic [nb_bit-1:0] divisor_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [nb_bit-1:0] quotient_o,
  output logic [nb_bit-1:0] remainder_o
`ifdef DIVIDER_DBZ_EN
  ,
  output logic              div_by_zero_o
`endif
);

  localparam int cnt_w = (nb_bit > 1) ? $clog2(nb_bit) : 1;
  localparam logic [cnt_w-1:0] cnt_last = cnt_w'(nb_bit - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_r;
  logic [nb_bit:0]   rem_r;
  logic [nb_bit-1:0] quo_r;
  logic [nb_bit-1:0] div_r;
  logic [cnt_w-1:0]  cnt_r;

  logic [nb_bit:0]   rem_shift_s;
  logic [nb_bit:0]   trial_s;
  logic              borrow_s;
  logic [nb_bit:0]   rem_next_s;
  logic [nb_bit-1:0] quo_next_s;

  assign rem_shift_s = {rem_r[nb_bit-1:0], quo_r[nb_bit-1]};

  subtractor_n #(.nb_bit(nb_bit + 1)) u_sub (
    .a_i      (rem_shift_s),
    .b_i      ({1'b0, div_r}),
    .diff_o   (trial_s),
    .borrow_o (borrow_s)
  );

  // Restore on borrow, otherwise keep the trial difference and shift in a 1.
  always_comb begin
    rem_next_s = rem_shift_s;
    quo_next_s = {quo_r[nb_bit-2:0], 1'b0};
    if (!borrow_s) begin
      rem_next_s = trial_s;
      quo_next_s = {quo_r[nb_bit-2:0], 1'b1};
    end else begin
      rem_next_s = rem_shift_s;
      quo_next_s = {quo_r[nb_bit-2:0], 1'b0};
    end
  end

  // Control FSM, iteration datapath and registered result outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r     <= IDLE;
      ready_o     <= 1'b1;
      valid_o     <= 1'b0;
      quotient_o  <= '0;
      remainder_o <= '0;
      rem_r       <= '0;
      quo_r       <= '0;
      div_r       <= '0;
      cnt_r       <= '0;
`ifdef DIVIDER_DBZ_EN
      div_by_zero_o <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (valid_i && ready_o) begin
            div_r   <= divisor_i;
            rem_r   <= '0;
            quo_r   <= dividend_i;
            cnt_r   <= '0;
            ready_o <= 1'b0;
`ifdef DIVIDER_DBZ_EN
            div_by_zero_o <= (divisor_i == '0);
            if (divisor_i == '0) begin
              // Valid is raised from DONE on the following edge.
              quotient_o  <= '1;
              remainder_o <= dividend_i;
              state_r     <= DONE;
            end else begin
              state_r <= CALC;
            end
`else
            state_r <= CALC;
`endif
          end
        end
        CALC: begin
          rem_r <= rem_next_s;
          quo_r <= quo_next_s;
          cnt_r <= cnt_r + cnt_w'(1);
          if (cnt_r == cnt_last) begin
            state_r     <= DONE;
            valid_o     <= 1'b1;
            quotient_o  <= quo_next_s;
            remainder_o <= rem_next_s[nb_bit-1:0];
          end
        end
        DONE: begin
          if (!valid_o) begin
            valid_o <= 1'b1;
          end else if (ready_i) begin
            valid_o <= 1'b0;
            ready_o <= 1'b1;
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
          ready_o <= 1'b1;
          valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_restoring_divider_n.sv
// Directed self-checking bench for restoring_divider_n (nb_bit = 8).
module tb_restoring_divider_n;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       valid_i;
  logic       ready_o;
  logic [7:0] dividend_i;
  logic [7:0] divisor_i;
  logic       valid_o;
  logic       ready_i;
  logic [7:0] quotient_o;
  logic [7:0] remainder_o;
`ifdef DIVIDER_DBZ_EN
  logic       div_by_zero_o;
`endif

  int checks = 0;
  int errors = 0;

  restoring_divider_n #(.nb_bit(8)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .dividend_i  (dividend_i),
    .divisor_i   (divisor_i),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .quotient_o  (quotient_o),
    .remainder_o (remainder_o)
`ifdef DIVIDER_DBZ_EN
    ,
    .div_by_zero_o (div_by_zero_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Counts edges until valid_o, bounded; also reports whether ready_o ever rose while busy.
  task automatic wait_valid(output int lat, output bit ready_seen);
    lat = 0;
    ready_seen = 1'b0;
    while (valid_o !== 1'b1 && lat < 40) begin
      if (ready_o !== 1'b0) ready_seen = 1'b1;
      tick();
      lat++;
    end
  endtask

  // Accepts one operation and waits for its result, leaving it unacknowledged.
  task automatic do_div(input logic [7:0] a, input logic [7:0] b,
                        output int lat, output bit ready_seen);
    dividend_i = a;
    divisor_i  = b;
    valid_i    = 1'b1;
    ready_i    = 1'b0;
    tick();
    valid_i = 1'b0;
    wait_valid(lat, ready_seen);
  endtask

  task automatic test_reset();
    rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b0;
    dividend_i = 8'd0; divisor_i = 8'd0;
    tick(); tick();
    rst_i = 1'b0;
    checks++;
    if (ready_o !== 1'b1 || valid_o !== 1'b0 || quotient_o !== 8'd0 || remainder_o !== 8'd0) begin
      errors++;
      $display("FAIL reset: ready=%b valid=%b q=%0d r=%0d, want 1 0 0 0", ready_o, valid_o, quotient_o, remainder_o);
    end
  endtask

  task automatic test_basic();
    int lat; bit rs;
    do_div(8'd100, 8'd7, lat, rs);
    checks++;
    if (lat !== 8 || quotient_o !== 8'd14 || remainder_o !== 8'd2 || rs !== 1'b0 || ready_o !== 1'b0) begin
      errors++;
      $display("FAIL basic_100_7: lat=%0d q=%0d r=%0d busy_ready=%b ready=%b, want 8 14 2 0 0",
               lat, quotient_o, remainder_o, rs, ready_o);
    end
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    checks++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1 || quotient_o !== 8'd14 || remainder_o !== 8'd2) begin
      errors++;
      $display("FAIL basic_release: valid=%b ready=%b q=%0d r=%0d, want 0 1 14 2", valid_o, ready_o, quotient_o, remainder_o);
    end
  endtask

  task automatic test_boundaries();
    logic [7:0] va [5] = '{8'd255, 8'd5, 8'd0, 8'd255, 8'd42};
    logic [7:0] vb [5] = '{8'd1,   8'd9, 8'd3, 8'd255, 8'd0};
    logic [7:0] vq [5] = '{8'd255, 8'd0, 8'd0, 8'd1,   8'd255};
    logic [7:0] vr [5] = '{8'd0,   8'd5, 8'd0, 8'd0,   8'd42};
    for (int i = 0; i < 5; i++) begin
      int lat; bit rs; int want_lat;
      want_lat = 8;
`ifdef DIVIDER_DBZ_EN
      if (vb[i] == 8'd0) want_lat = 1;
`endif
      do_div(va[i], vb[i], lat, rs);
      checks++;
      if (lat !== want_lat || quotient_o !== vq[i] || remainder_o !== vr[i] || rs !== 1'b0) begin
        errors++;
        $display("FAIL boundary_%0d_%0d: lat=%0d q=%0d r=%0d busy_ready=%b, want %0d %0d %0d 0",
                 va[i], vb[i], lat, quotient_o, remainder_o, rs, want_lat, vq[i], vr[i]);
      end
`ifdef DIVIDER_DBZ_EN
      checks++;
      if (div_by_zero_o !== (vb[i] == 8'd0)) begin
        errors++;
        $display("FAIL dbz_flag_%0d_%0d: got %b want %b", va[i], vb[i], div_by_zero_o, (vb[i] == 8'd0));
      end
`endif
      ready_i = 1'b1;
      tick();
      ready_i = 1'b0;
    end
  endtask

  task automatic test_backpressure();
    int lat; bit rs;
    do_div(8'd200, 8'd13, lat, rs);
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (valid_o !== 1'b1 || ready_o !== 1'b0 || quotient_o !== 8'd15 || remainder_o !== 8'd5) begin
        errors++;
        $display("FAIL hold_cycle_%0d: valid=%b ready=%b q=%0d r=%0d, want 1 0 15 5", k, valid_o, ready_o, quotient_o, remainder_o);
      end
      tick();
    end
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    checks++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
      errors++;
      $display("FAIL hold_release: valid=%b ready=%b, want 0 1", valid_o, ready_o);
    end
  endtask

  task automatic test_reset_mid();
    int lat; bit rs;
    dividend_i = 8'd77; divisor_i = 8'd5; valid_i = 1'b1; ready_i = 1'b0;
    tick();
    valid_i = 1'b0;
    tick(); tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    checks++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1 || quotient_o !== 8'd0 || remainder_o !== 8'd0) begin
      errors++;
      $display("FAIL reset_mid_calc: valid=%b ready=%b q=%0d r=%0d, want 0 1 0 0", valid_o, ready_o, quotient_o, remainder_o);
    end
    tick();
    checks++;
    if (valid_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_result: valid=%b want 0", valid_o);
    end
    do_div(8'd77, 8'd5, lat, rs);
    checks++;
    if (lat !== 8 || quotient_o !== 8'd15 || remainder_o !== 8'd2) begin
      errors++;
      $display("FAIL after_reset_77_5: lat=%0d q=%0d r=%0d, want 8 15 2", lat, quotient_o, remainder_o);
    end
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
  endtask

  task automatic test_back_to_back();
    int lat; bit rs;
    dividend_i = 8'd100; divisor_i = 8'd7; valid_i = 1'b1; ready_i = 1'b0;
    tick();
    tick(); tick();
    dividend_i = 8'd9; divisor_i = 8'd3;
    wait_valid(lat, rs);
    lat = lat + 2;
    checks++;
    if (lat !== 8 || quotient_o !== 8'd14 || remainder_o !== 8'd2 || rs !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first: lat=%0d q=%0d r=%0d busy_ready=%b, want 8 14 2 0", lat, quotient_o, remainder_o, rs);
    end
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    checks++;
    if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
      errors++;
      $display("FAIL b2b_reaccept_gap: ready=%b valid=%b, want 1 0", ready_o, valid_o);
    end
    tick();
    valid_i = 1'b0;
    wait_valid(lat, rs);
    checks++;
    if (lat !== 8 || quotient_o !== 8'd3 || remainder_o !== 8'd0) begin
      errors++;
      $display("FAIL b2b_second: lat=%0d q=%0d r=%0d, want 8 3 0", lat, quotient_o, remainder_o);
    end
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundaries();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
